// File: rtl/spi_io_pkg.sv
// Shared definitions for the starter-kit analog SPI bus: FSM encoding,
// frame geometry and the bit-index type used by the SCK generator.
package spi_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_AMP_SHIFT = 3'd1,
        ST_AMP_GAP   = 3'd2,
        ST_CONV      = 3'd3,
        ST_ADC_SHIFT = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam int ADC_BITS = 34;
    localparam int AMP_BITS = 8;
    localparam int A_FIRST  = 2;
    localparam int B_FIRST  = 18;
    localparam int SAMPLE_W = 14;

    localparam int BIT_IDX_W = 6;
    typedef logic [BIT_IDX_W-1:0] bit_idx_t;

    localparam bit_idx_t ADC_LAST_IDX = bit_idx_t'(ADC_BITS - 1);
    localparam bit_idx_t AMP_LAST_IDX = bit_idx_t'(AMP_BITS - 1);

    // True when SCK period idx carries one of the SAMPLE_W bits starting at first.
    function automatic logic in_window(input bit_idx_t idx, input int first);
        return (int'(idx) >= first) && (int'(idx) < first + SAMPLE_W);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV-cycle half periods (low phase first), rise/fall
// strobes one cycle ahead of the sck edge, and a period counter with terminal flag.
module spi_sck_gen
    import spi_io_pkg::*;
#(
    parameter int CLK_DIV = 4
)
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_en,
    input  bit_idx_t i_last_idx,
    output logic     o_sck,
    output logic     o_rise,
    output logic     o_fall,
    output bit_idx_t o_bit_idx,
    output logic     o_last
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sck;
    bit_idx_t         r_bit_idx;
    logic             w_tick;

    assign w_tick = i_en && (r_div_cnt == DIV_LAST);

    // Dropping i_en parks the generator so every train starts on a fresh low phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
            r_bit_idx <= '0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
            r_bit_idx <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            if (r_sck) begin
                r_bit_idx <= r_bit_idx + bit_idx_t'(1);
            end
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign o_sck     = r_sck;
    assign o_rise    = w_tick && !r_sck;
    assign o_fall    = w_tick && r_sck;
    assign o_bit_idx = r_bit_idx;
    assign o_last    = (r_bit_idx == i_last_idx);

endmodule

// File: rtl/spi_adc_rx.sv
// LTC6912 gain write + LTC1407A-1 dual-channel capture. The FSM runs one
// cycle ahead of the pins: every output is a register of the decoded state.
module spi_adc_rx
    import spi_io_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CONV_CYC = 2
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AMP_BITS-1:0] amp_in,
    input  logic                spi_sdi,
    output logic                spi_sck,
    output logic                spi_sdo,
    output logic                spi_amp_cs,
    output logic                spi_adc_conv,
    output logic                busy,
    output logic [SAMPLE_W-1:0] adc_a_out,
    output logic [SAMPLE_W-1:0] adc_b_out,
    output logic                adc_valid,
    output state_t              dbg_state
);

    localparam int GAP_CYC  = 2 * CLK_DIV;
    localparam int WAIT_MAX = (GAP_CYC > CONV_CYC) ? GAP_CYC : CONV_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(GAP_CYC - 1);
    localparam logic [WAIT_W-1:0] CONV_LAST = WAIT_W'(CONV_CYC - 1);

    state_t              r_state, w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [AMP_BITS-1:0] r_gain, r_amp_sh;
    logic                r_amp_pending;
    logic [SAMPLE_W-1:0] r_sh_a, r_sh_b, r_adc_a, r_adc_b;
    logic                r_cap;
    bit_idx_t            r_cap_idx;
    logic                r_sck, r_sdo, r_amp_cs, r_conv, r_busy, r_valid;

    logic     w_gen_en, w_gen_sck, w_rise, w_fall, w_last, w_shift_done, w_amp_entry;
    bit_idx_t w_bit_idx, w_last_idx;
    logic     w_sck_d, w_sdo_d, w_cs_d, w_conv_d, w_busy_d, w_valid_d;

    assign w_gen_en     = (r_state == ST_AMP_SHIFT) || (r_state == ST_ADC_SHIFT);
    assign w_last_idx   = (r_state == ST_ADC_SHIFT) ? ADC_LAST_IDX : AMP_LAST_IDX;
    assign w_shift_done = w_fall && w_last;
    assign w_amp_entry  = (r_state == ST_IDLE) && (w_next_state == ST_AMP_SHIFT);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_gen_en),
        .i_last_idx (w_last_idx),
        .o_sck      (w_gen_sck),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_bit_idx  (w_bit_idx),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // start is a single-cycle request with no ready: it is taken only when the
    // FSM sits in IDLE and is silently dropped in every other state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:      if (start) w_next_state = r_amp_pending ? ST_AMP_SHIFT : ST_CONV;
            ST_AMP_SHIFT: if (w_shift_done) w_next_state = ST_AMP_GAP;
            ST_AMP_GAP:   if (r_wait_cnt == GAP_LAST) w_next_state = ST_CONV;
            ST_CONV:      if (r_wait_cnt == CONV_LAST) w_next_state = ST_ADC_SHIFT;
            ST_ADC_SHIFT: if (w_shift_done) w_next_state = ST_DONE;
            ST_DONE:      w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sck_d   = 1'b0;
        w_sdo_d   = 1'b0;
        w_cs_d    = 1'b1;
        w_conv_d  = 1'b0;
        w_busy_d  = 1'b1;
        w_valid_d = 1'b0;
        unique case (r_state)
            ST_IDLE:      w_busy_d = 1'b0;
            ST_AMP_SHIFT: begin
                w_sck_d = w_gen_sck;
                w_sdo_d = r_amp_sh[AMP_BITS-1];
                w_cs_d  = 1'b0;
            end
            ST_AMP_GAP:   w_busy_d = 1'b1;
            ST_CONV:      w_conv_d = 1'b1;
            ST_ADC_SHIFT: w_sck_d = w_gen_sck;
            ST_DONE: begin
                w_busy_d  = 1'b0;
                w_valid_d = 1'b1;
            end
            default:      w_busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != w_next_state) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_AMP_GAP) || (r_state == ST_CONV)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // The word in flight is frozen at entry; later amp_in changes only re-arm pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gain        <= '0;
            r_amp_sh      <= '0;
            r_amp_pending <= 1'b1;
        end else if (w_amp_entry) begin
            r_gain        <= amp_in;
            r_amp_sh      <= amp_in;
            r_amp_pending <= 1'b0;
        end else begin
            if (amp_in != r_gain) begin
                r_amp_pending <= 1'b1;
            end
            if ((r_state == ST_AMP_SHIFT) && w_fall) begin
                r_amp_sh <= {r_amp_sh[AMP_BITS-2:0], 1'b0};
            end
        end
    end

    // r_cap lines up with the cycle in which the spi_sck pin itself goes high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap     <= 1'b0;
            r_cap_idx <= '0;
            r_sh_a    <= '0;
            r_sh_b    <= '0;
        end else begin
            r_cap     <= w_rise && (r_state == ST_ADC_SHIFT);
            r_cap_idx <= w_bit_idx;
            if (r_cap && in_window(r_cap_idx, A_FIRST)) begin
                r_sh_a <= {r_sh_a[SAMPLE_W-2:0], spi_sdi};
            end
            if (r_cap && in_window(r_cap_idx, B_FIRST)) begin
                r_sh_b <= {r_sh_b[SAMPLE_W-2:0], spi_sdi};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck    <= 1'b0;
            r_sdo    <= 1'b0;
            r_amp_cs <= 1'b1;
            r_conv   <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_adc_a  <= '0;
            r_adc_b  <= '0;
        end else begin
            r_sck    <= w_sck_d;
            r_sdo    <= w_sdo_d;
            r_amp_cs <= w_cs_d;
            r_conv   <= w_conv_d;
            r_busy   <= w_busy_d;
            r_valid  <= w_valid_d;
            if (r_state == ST_DONE) begin
                r_adc_a <= r_sh_a;
                r_adc_b <= r_sh_b;
            end
        end
    end

    assign spi_sck      = r_sck;
    assign spi_sdo      = r_sdo;
    assign spi_amp_cs   = r_amp_cs;
    assign spi_adc_conv = r_conv;
    assign busy         = r_busy;
    assign adc_valid    = r_valid;
    assign adc_a_out    = r_adc_a;
    assign adc_b_out    = r_adc_b;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_spi_adc_rx.sv
// Bench for spi_adc_rx: LTC1407A-style serial source, amp-word monitor,
// and a scoreboard of expected captures with their completion cycle.
module tb_spi_adc_rx;
    import spi_io_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int CONV_CYC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  amp_in = 8'h00;
    logic        spi_sdi = 1'b0;
    logic        spi_sck, spi_sdo, spi_amp_cs, spi_adc_conv, busy, adc_valid;
    logic [13:0] adc_a_out, adc_b_out;
    state_t      dbg_state;

    spi_adc_rx #(.CLK_DIV(CLK_DIV), .CONV_CYC(CONV_CYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .amp_in       (amp_in),
        .spi_sdi      (spi_sdi),
        .spi_sck      (spi_sck),
        .spi_sdo      (spi_sdo),
        .spi_amp_cs   (spi_amp_cs),
        .spi_adc_conv (spi_adc_conv),
        .busy         (busy),
        .adc_a_out    (adc_a_out),
        .adc_b_out    (adc_b_out),
        .adc_valid    (adc_valid),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        int          t;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_amp_q[$];
    int         checks = 0;
    int         failures = 0;

    // Reference state: last gain word written, pending flag, last published samples.
    logic [7:0]  model_gain = 8'h00;
    bit          model_pending = 1'b1;
    logic [13:0] last_a = '0, last_b = '0;
    int          t0 = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    // ADC model: bit 0 presented at CONV, next bit after every SCK fall.
    logic [33:0] frame = '0;
    int          adc_n = 0;
    always @(posedge spi_adc_conv) begin
        adc_n   = 0;
        spi_sdi = frame[33];
    end
    always @(negedge spi_sck) begin
        adc_n   = adc_n + 1;
        spi_sdi = (adc_n < 34) ? frame[6'(33 - adc_n)] : 1'b1;
    end

    // Amp monitor: collect sdo on each SCK rise while the amp is selected.
    logic [7:0] amp_word = '0;
    int         amp_nbits = 0;
    bit         amp_active = 1'b0;
    always @(negedge spi_amp_cs) begin
        amp_active = 1'b1;
        amp_nbits  = 0;
        amp_word   = '0;
    end
    always @(posedge spi_sck) begin
        if (amp_active) begin
            amp_word  = {amp_word[6:0], spi_sdo};
            amp_nbits = amp_nbits + 1;
        end
    end
    always @(posedge spi_amp_cs) begin
        logic [7:0] req;
        if (amp_active) begin
            amp_active = 1'b0;
            if (exp_amp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL amp_unexpected actual=%0h required=no write", amp_word);
            end else begin
                req = exp_amp_q.pop_front();
                chk("amp_word", 32'(amp_word), 32'(req));
                chk("amp_nbits", 32'(amp_nbits), 32'd8);
            end
        end
    end

    // Capture monitor.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (adc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL valid_unexpected actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(e.t));
                chk("adc_a", 32'(adc_a_out), 32'(e.a));
                chk("adc_b", 32'(adc_b_out), 32'(e.b));
                chk("busy_at_valid", 32'(busy), 32'd0);
            end
        end
    end

    task automatic set_amp(input logic [7:0] v);
        amp_in = v;
        if (v != model_gain) model_pending = 1'b1;
    endtask

    task automatic wait_rel(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; start is sampled at the next posedge (relative cycle 0).
    task automatic issue(input logic [13:0] a, input logic [13:0] b, input logic [5:0] dummy);
        exp_t e;
        bit   wr;
        int   lat;
        chk("hold_a", 32'(adc_a_out), 32'(last_a));
        chk("hold_b", 32'(adc_b_out), 32'(last_b));
        wr    = model_pending;
        frame = {dummy[5:4], a, dummy[3:2], b, dummy[1:0]};
        lat   = 1 + CONV_CYC + 68 * CLK_DIV + (wr ? 18 * CLK_DIV : 0);
        t0    = cyc + 1;
        e.a = a;
        e.b = b;
        e.t = t0 + lat;
        exp_q.push_back(e);
        if (wr) begin
            exp_amp_q.push_back(amp_in);
            model_gain    = amp_in;
            model_pending = 1'b0;
        end
        last_a = a;
        last_b = b;
        pulse_start();
        chk("busy_c0", 32'(busy), 32'd0);
        @(negedge clk);
        chk("busy_c1", 32'(busy), 32'd1);
        if (wr) chk("amp_cs_c1", 32'(spi_amp_cs), 32'd0);
        else    chk("conv_c1", 32'(spi_adc_conv), 32'd1);
    endtask

    task automatic issue_rand();
        issue(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 6'($urandom_range(0, 63)));
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || exp_amp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL done_timeout actual=%0d pending required=0", exp_q.size() + exp_amp_q.size());
            exp_q.delete();
            exp_amp_q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sck"},   32'(spi_sck),      32'd0);
        chk({tag, "_sdo"},   32'(spi_sdo),      32'd0);
        chk({tag, "_cs"},    32'(spi_amp_cs),   32'd1);
        chk({tag, "_conv"},  32'(spi_adc_conv), 32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_valid"}, 32'(adc_valid),    32'd0);
        chk({tag, "_a"},     32'(adc_a_out),    32'd0);
        chk({tag, "_b"},     32'(adc_b_out),    32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // First capture writes the gain word 0x11.
        set_amp(8'h11);
        repeat (2) @(negedge clk);
        issue_rand();
        wait_done();

        // Known pattern with all dummy bits high; amp is not rewritten.
        issue(14'h2ABC, 14'h1F03, 6'h3F);
        wait_done();

        // Negative full scale, no sign extension.
        issue(14'h2000, 14'h3FFF, 6'($urandom_range(0, 63)));
        wait_done();

        // Starts at 50 and 275 are dropped; the one at 276 is taken.
        issue_rand();
        wait_rel(49);
        pulse_start();
        wait_rel(274);
        pulse_start();
        issue_rand();
        wait_done();

        // amp_in change during the ADC shift re-arms the write for the next capture.
        issue_rand();
        wait_rel(150);
        set_amp(8'h5A);
        wait_done();
        issue_rand();
        wait_rel(30);
        set_amp(8'hC3);
        wait_done();
        issue_rand();
        wait_done();

        // Asynchronous reset mid-capture.
        issue_rand();
        wait_rel(100);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        model_gain    = 8'h00;
        model_pending = 1'b1;
        last_a        = '0;
        last_b        = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue_rand();
        wait_done();

        // Randomised captures with occasional gain changes.
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) set_amp(8'($urandom_range(0, 255)));
            repeat ($urandom_range(2, 5)) @(negedge clk);
            issue_rand();
            wait_done();
        end

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("exp_amp_q_empty", 32'(exp_amp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
